// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and widths for the multiplier arbiter
package mult_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic req_id_t;

endpackage

// File: rtl/wallatree.sv
// rtl/wallatree.sv - combinational 4x4 unsigned multiplier, carry-save reduction of partial products
module wallatree
   import mult_pkg::*;
(
   input  logic [OP_W-1:0]   A,
   input  logic [OP_W-1:0]   B,
   output logic [PROD_W-1:0] prod
);

   logic [PROD_W-1:0] pp [OP_W];
   logic [PROD_W-1:0] s1, c1, s2, c2;

   always_comb begin
      for (int i = 0; i < OP_W; i++) begin
         pp[i] = B[i] ? (PROD_W'(A) << i) : '0;
      end
   end

   // Two 3:2 compressor levels; truncation to 8 bits is exact since the product never exceeds 225.
   assign s1 = pp[0] ^ pp[1] ^ pp[2];
   assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
   assign s2 = s1 ^ c1 ^ pp[3];
   assign c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;

   assign prod = s2 + c2;

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two requesters share one 4x4 multiplier; optional self-check under MULT_ARBITER_CHECK_EN
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int FAIR = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [OP_W-1:0]   req0_a,
   input  logic [OP_W-1:0]   req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [OP_W-1:0]   req1_a,
   input  logic [OP_W-1:0]   req1_b,
   output logic              req1_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [PROD_W-1:0] rsp_prod,
   output logic              busy,
   output logic              chk_err
);

   state_t            state;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   req_id_t           op_id;
   req_id_t           rr_next;
   logic              grant0;
   logic [PROD_W-1:0] mul_prod;

   // rr_next names the requester that wins a tie; fixed priority ignores it.
   assign grant0     = req0_valid && (!req1_valid || (FAIR == 0) || (rr_next == 1'b0));
   assign req0_ready = rst_n && (state == IDLE) && grant0;
   assign req1_ready = rst_n && (state == IDLE) && req1_valid && !grant0;
   assign busy       = (state != IDLE);

   wallatree u_mul (
      .A    (op_a),
      .B    (op_b),
      .prod (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= 1'b0;
         rr_next   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_prod  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  op_a    <= grant0 ? req0_a : req1_a;
                  op_b    <= grant0 ? req0_b : req1_b;
                  op_id   <= ~grant0;
                  rr_next <= grant0;
                  state   <= MUL;
               end
            end
            MUL: begin
               rsp_prod  <= mul_prod;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MULT_ARBITER_CHECK_EN
   logic [PROD_W-1:0] ref_prod;
   assign ref_prod = PROD_W'(op_a) * PROD_W'(op_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err <= 1'b0;
      end else if ((state == MUL) && (mul_prod != ref_prod)) begin
         chk_err <= 1'b1;
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter (round-robin and fixed priority)
module tb_mult_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid, rsp_ready;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;

   logic       rr_ready0, rr_ready1, rr_valid, rr_id, rr_busy, rr_err;
   logic [7:0] rr_prod;
   logic       fp_ready0, fp_ready1, fp_valid, fp_id, fp_busy, fp_err;
   logic [7:0] fp_prod;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mult_arbiter #(.FAIR(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rr_ready0),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rr_ready1),
      .rsp_valid(rr_valid), .rsp_ready(rsp_ready), .rsp_id(rr_id), .rsp_prod(rr_prod),
      .busy(rr_busy), .chk_err(rr_err)
   );

   mult_arbiter #(.FAIR(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(fp_ready0),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(fp_ready1),
      .rsp_valid(fp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_id), .rsp_prod(fp_prod),
      .busy(fp_busy), .chk_err(fp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single-requester operation with rsp_ready=1; starts and ends at a negedge with both DUTs idle.
   task automatic op(input int who, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] exp_prod;
      exp_prod = 8'(a) * 8'(b);
      if (who == 0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end
      #1;
      check("op_ready0", {rr_ready0, fp_ready0}, (who == 0) ? 2'b11 : 2'b00);
      check("op_ready1", {rr_ready1, fp_ready1}, (who == 1) ? 2'b11 : 2'b00);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
      check("op_mul_busy", {rr_busy, rr_valid}, 2'b10);
      @(negedge clk);
      check("op_rsp_valid", {rr_valid, fp_valid}, 2'b11);
      check("op_rsp_prod", rr_prod, exp_prod);
      check("op_rsp_prod_fp", fp_prod, exp_prod);
      check("op_rsp_id", rr_id, who[0]);
      @(negedge clk);
      check("op_done", {rr_valid, rr_busy}, 2'b00);
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h3;
      req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0;
      #1;
      check("rst_rsp_valid", rr_valid, 1'b0);
      check("rst_rsp_id", rr_id, 1'b0);
      check("rst_rsp_prod", rr_prod, 8'h00);
      check("rst_busy", rr_busy, 1'b0);
      check("rst_chk_err", rr_err, 1'b0);
      check("rst_ready", {rr_ready0, rr_ready1, fp_ready0}, 3'b000);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);

      // 15*15 from requester 0
      op(0, 4'hF, 4'hF);

      // Response stall: requester 1 accepted, consumer holds off for 5 cycles
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'h6;
      #1;
      check("stall_ready1", rr_ready1, 1'b1);
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h2;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", rr_valid, 1'b1);
         check("stall_prod", rr_prod, 8'h36);
         check("stall_id", rr_id, 1'b1);
         check("stall_no_ready", {rr_ready0, rr_ready1, fp_ready0, fp_ready1}, 4'b0000);
         @(negedge clk);
      end
      rsp_ready = 1'b1; req0_valid = 1'b0;
      @(negedge clk);
      check("stall_release", {rr_valid, rr_busy}, 2'b00);

      // Both valid continuously: round-robin alternates, fixed priority always 0
      req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3;
      req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h7;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("both_rr_grant", {rr_ready0, rr_ready1}, (k % 2 == 0) ? 2'b10 : 2'b01);
         check("both_fp_grant", {fp_ready0, fp_ready1}, 2'b10);
         @(negedge clk);
         check("both_ignored", {rr_ready0, rr_ready1, fp_ready0, fp_ready1}, 4'b0000);
         @(negedge clk);
         check("both_rr_id", rr_id, (k % 2 == 0) ? 1'b0 : 1'b1);
         check("both_rr_prod", rr_prod, (k % 2 == 0) ? 8'd6 : 8'd35);
         check("both_fp_id", fp_id, 1'b0);
         check("both_fp_prod", fp_prod, 8'd6);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      // Reset asserted while in MUL discards the operation
      req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h5;
      @(negedge clk);
      req0_valid = 1'b0;
      check("mid_busy", rr_busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_state", {rr_valid, rr_busy, rr_id}, 3'b000);
      check("mid_rst_prod", {rr_prod, fp_prod}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_no_rsp", {rr_valid, fp_valid, rr_busy}, 3'b000);
      end
      req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1;
      req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h4;
      #1;
      check("post_rst_first", {rr_ready0, rr_ready1}, 2'b10);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check("post_rst_rsp", {rr_valid, rr_id, rr_prod}, {1'b1, 1'b0, 8'h01});
      @(negedge clk);

      // Exhaustive sweep, alternating requesters
      for (int i = 0; i < 256; i++) begin
         logic [7:0] ab;
         ab = 8'(i);
         op(i % 2, ab[7:4], ab[3:0]);
      end
      check("sweep_chk_err", {rr_err, fp_err}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
